regfile_32x64: RTL

REGFILE_32X64 -- requirements
Module: regfile_32x64

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_32x64_decoder.sv | 21 ++
 rtl/regfile_32x64.sv | 72 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the 32-entry x 64-bit register file.
// Index 31 is the architectural zero register (XZR) and has no storage.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    // Number of registers that actually hold state (X0..X30)
    localparam int NUM_PHYS = NUM_REGS - 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/regfile_32x64_decoder.sv
// Write-enable decoder: turns the write strobe and write address into a
// one-hot select over all 32 indices. The XZR position (bit 31) never
// asserts, so a write aimed at XZR selects no register and the same vector
// can be reused directly as the per-address bypass qualifier.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [NUM_REGS-1:0] o_sel
);

    // One-hot decode, gated by the strobe; XZR decodes to nothing
    always_comb begin
        o_sel = '0;
        if (i_en && (i_addr != ZERO_REG)) begin
            o_sel[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_32x64.sv
// 31 x 64-bit register file with a hardwired-zero XZR at index 31,
// one synchronous write port and two combinational read ports with
// same-cycle write-to-read bypass. Reset is synchronous and active-low;
// while reset is low the bypass is suppressed and the write is lost.
module regfile_32x64
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [DATA_W-1:0]   r_regs [0:NUM_PHYS-1];
    logic [NUM_REGS-1:0] w_wrSel;
    logic [DATA_W-1:0]   w_rd1Stored;
    logic [DATA_W-1:0]   w_rd2Stored;
    logic                w_byp1;
    logic                w_byp2;

    decoder_5to32 u_decoder (
        .i_en   (write_en),
        .i_addr (write_addr),
        .o_sel  (w_wrSel)
    );

    // Storage: each register clears on reset, otherwise loads only when selected
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PHYS; i++) begin
            if (!reset) begin
                r_regs[i] <= '0;
            end else if (w_wrSel[i]) begin
                r_regs[i] <= write_data;
            end
        end
    end

    // Port-1 32:1 mux over stored values; XZR and unmatched indices read zero
    always_comb begin
        w_rd1Stored = '0;
        for (int i = 0; i < NUM_PHYS; i++) begin
            if (read_addr1 == ADDR_W'(i)) begin
                w_rd1Stored = r_regs[i];
            end
        end
    end

    // Port-2 32:1 mux over stored values; XZR and unmatched indices read zero
    always_comb begin
        w_rd2Stored = '0;
        for (int i = 0; i < NUM_PHYS; i++) begin
            if (read_addr2 == ADDR_W'(i)) begin
                w_rd2Stored = r_regs[i];
            end
        end
    end

    // Bypass qualifier: the decoder already excludes XZR and idle cycles,
    // so only the reset gate remains to be applied here
    assign w_byp1 = reset & w_wrSel[read_addr1];
    assign w_byp2 = reset & w_wrSel[read_addr2];

    // 2:1 bypass mux after the read mux on each port
    assign read_data1 = w_byp1 ? write_data : w_rd1Stored;
    assign read_data2 = w_byp2 ? write_data : w_rd2Stored;

endmodule
